// File: rtl/microstep_pkg.sv
// Shared definitions for the microstep datapath: opcode encodings and the
// sequencer state encoding.
package microstep_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD     = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB     = 4'd1;
  localparam logic [OP_W-1:0] OP_AND     = 4'd2;
  localparam logic [OP_W-1:0] OP_OR      = 4'd3;
  localparam logic [OP_W-1:0] OP_SHR     = 4'd4;
  localparam logic [OP_W-1:0] OP_SHRA    = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL     = 4'd6;
  localparam logic [OP_W-1:0] OP_ROR     = 4'd7;
  localparam logic [OP_W-1:0] OP_ROL     = 4'd8;
  localparam logic [OP_W-1:0] OP_NEG     = 4'd9;
  localparam logic [OP_W-1:0] OP_NOT     = 4'd10;
  localparam logic [OP_W-1:0] OP_ADDI    = 4'd11;
  localparam logic [OP_W-1:0] OP_RSVD_LO = 4'd12;
  localparam logic [OP_W-1:0] OP_RSVD_HI = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOADY = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  // Opcodes 12..15 are reserved and execute as a no-write error.
  function automatic logic op_is_rsvd(input logic [OP_W-1:0] op);
    return (op >= OP_RSVD_LO) && (op <= OP_RSVD_HI);
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for the microstep datapath.
// Ports: a (operand A, from Y), b (operand B), op (opcode), c (result).
// Shift/rotate amount is b modulo DATA_W; reserved opcodes yield 0.
module dp_alu
  import microstep_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] c
);

  localparam int unsigned SH_W = $clog2(DATA_W);
  localparam logic [SH_W:0] WIDTH_L = (SH_W+1)'(DATA_W);

  logic [SH_W-1:0] amt;
  logic [SH_W:0]   amt_inv;

  // Rotates are built from two shifts; a complement shift of DATA_W yields 0,
  // so an amount of 0 passes A through unchanged.
  always_comb begin
    amt     = b[SH_W-1:0];
    amt_inv = WIDTH_L - {1'b0, amt};
    c       = '0;
    case (op)
      OP_ADD:  c = a + b;
      OP_SUB:  c = a - b;
      OP_AND:  c = a & b;
      OP_OR:   c = a | b;
      OP_SHR:  c = a >> amt;
      OP_SHRA: c = $unsigned($signed(a) >>> amt);
      OP_SHL:  c = a << amt;
      OP_ROR:  c = (a >> amt) | (a << amt_inv);
      OP_ROL:  c = (a << amt) | (a >> amt_inv);
      OP_NEG:  c = '0 - b;
      OP_NOT:  c = ~b;
      OP_ADDI: c = a + b;
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/microstep_datapath.sv
// Register-file datapath with a built-in four-state sequencer that executes
// one ALU instruction per start/done handshake.
// Ports: Clock/Clear (sync active-high reset); start/op/ra/rb/rc/imm request
// an instruction; busy/done/err/result/flag_z/flag_n report it; wr_en/wr_addr/
// wr_data preload registers while idle; dbg_addr/dbg_data read any register.
module microstep_datapath
  import microstep_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter bit          R0_ZERO  = 1'b1
) (
  input  logic                        Clock,
  input  logic                        Clear,
  input  logic                        start,
  input  logic [OP_W-1:0]             op,
  input  logic [$clog2(NUM_REGS)-1:0] ra,
  input  logic [$clog2(NUM_REGS)-1:0] rb,
  input  logic [$clog2(NUM_REGS)-1:0] rc,
  input  logic [DATA_W-1:0]           imm,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [DATA_W-1:0]           result,
  output logic                        flag_z,
  output logic                        flag_n,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_data
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  state_e            state_q,  state_d;
  logic [OP_W-1:0]   op_q,     op_d;
  logic [AW-1:0]     ra_q,     ra_d;
  logic [AW-1:0]     rc_q,     rc_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [DATA_W-1:0] y_q,      y_d;
  logic [DATA_W-1:0] z_q,      z_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic              err_q,    err_d;
  logic              done_q,   done_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [DATA_W-1:0] rb_val, rc_val, alu_b, alu_c;

  // Register reads apply the hardwired-zero R0 rule.
  assign rb_val   = (R0_ZERO && (rb == '0))       ? '0 : regs_q[rb];
  assign rc_val   = (R0_ZERO && (rc_q == '0))     ? '0 : regs_q[rc_q];
  assign dbg_data = (R0_ZERO && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];

  assign alu_b = (op_q == OP_ADDI) ? imm_q : rc_val;

  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (y_q),
    .b  (alu_b),
    .op (op_q),
    .c  (alu_c)
  );

  // Sequencer next-state, register-file and handshake updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rc_d     = rc_q;
    imm_d    = imm_q;
    y_d      = y_q;
    z_d      = z_q;
    result_d = result_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    err_d    = err_q;
    done_d   = 1'b0;
    regs_d   = regs_q;

    case (state_q)
      S_IDLE: begin
        if (wr_en && !(R0_ZERO && (wr_addr == '0))) begin
          regs_d[wr_addr] = wr_data;
        end
        if (start) begin
          op_d    = op;
          ra_d    = ra;
          rc_d    = rc;
          imm_d   = imm;
          y_d     = rb_val;
          err_d   = 1'b0;
          state_d = S_LOADY;
        end
      end
      S_LOADY: begin
        z_d     = alu_c;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!op_is_rsvd(op_q) && !(R0_ZERO && (ra_q == '0))) begin
          regs_d[ra_q] = z_q;
        end
        result_d = z_q;
        flag_z_d = (z_q == '0);
        flag_n_d = z_q[DATA_W-1];
        err_d    = op_is_rsvd(op_q);
        done_d   = 1'b1;
        state_d  = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; Clear abandons any instruction in flight.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rc_q     <= '0;
      imm_q    <= '0;
      y_q      <= '0;
      z_q      <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      regs_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rc_q     <= rc_d;
      imm_q    <= imm_d;
      y_q      <= y_d;
      z_q      <= z_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      err_q    <= err_d;
      done_q   <= done_d;
      regs_q   <= regs_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;

endmodule

// File: tb/tb_microstep_datapath.sv
// Scoreboard bench for microstep_datapath with default parameters.
module tb_microstep_datapath;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned AW       = 4;

  logic              Clock = 1'b0;
  logic              Clear;
  logic              start;
  logic [3:0]        op;
  logic [AW-1:0]     ra, rb, rc;
  logic [DATA_W-1:0] imm;
  logic              busy, done, err, flag_z, flag_n;
  logic [DATA_W-1:0] result;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  microstep_datapath #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .R0_ZERO(1'b1)) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .op(op), .ra(ra), .rb(rb),
    .rc(rc), .imm(imm), .busy(busy), .done(done), .err(err), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [NUM_REGS];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reference ALU; shifts and rotates are done one bit at a time.
  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    int          amt;
    amt = int'(b[4:0]);
    r   = a;
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  for (int i = 0; i < amt; i++) r = {1'b0, r[31:1]};
      4'd5:  for (int i = 0; i < amt; i++) r = {r[31], r[31:1]};
      4'd6:  for (int i = 0; i < amt; i++) r = {r[30:0], 1'b0};
      4'd7:  for (int i = 0; i < amt; i++) r = {r[0], r[31:1]};
      4'd8:  for (int i = 0; i < amt; i++) r = {r[30:0], r[31]};
      4'd9:  r = 32'd0 - b;
      4'd10: r = ~b;
      4'd11: r = a + b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(posedge Clock) begin
    exp_t e;
    #1;
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("result", result, e.res);
        check_eq("flag_z", 32'(flag_z), 32'(e.z));
        check_eq("flag_n", 32'(flag_n), 32'(e.n));
        check_eq("err", 32'(err), 32'(e.e));
      end
    end
  end

  task automatic do_clear();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'd0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a != 0) mdl[a] = d;
  endtask

  task automatic check_reg(input string tag, input logic [AW-1:0] a);
    dbg_addr = a;
    #1;
    check_eq(tag, dbg_data, mdl[a]);
  endtask

  function automatic exp_t predict(input logic [3:0] o, input logic [AW-1:0] s,
                                   input logic [AW-1:0] t, input logic [31:0] iv);
    exp_t        e;
    logic [31:0] b;
    b     = (o == 4'd11) ? iv : mdl[t];
    e.e   = (o >= 4'd12);
    e.res = e.e ? 32'd0 : ref_alu(o, mdl[s], b);
    e.z   = (e.res == 32'd0);
    e.n   = e.res[31];
    return e;
  endfunction

  // One full instruction with handshake timing checks.
  task automatic run(input logic [3:0] o, input logic [AW-1:0] d, input logic [AW-1:0] s,
                     input logic [AW-1:0] t, input logic [31:0] iv);
    exp_t e;
    int   lat;
    e = predict(o, s, t, iv);
    sb.push_back(e);
    start = 1'b1; op = o; ra = d; rb = s; rc = t; imm = iv;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin
      check_eq("busy_in_flight", 32'(busy), 32'd1);
      tick();
      lat++;
    end
    check_eq("done_latency", lat, 2);
    check_eq("busy_in_wb", 32'(busy), 32'd1);
    tick();
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_after_wb", 32'(busy), 32'd0);
    check_eq("result_held", result, e.res);
    if (!e.e && d != 0) mdl[d] = e.res;
    check_reg("dbg_ra", d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   d0;
    exp_t e;
    Clear = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0; imm = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    tick();
    do_clear();

    // Reset state
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_reg("rst_r5", 4'd5);

    // 1: basic ADD
    host_write(4'd2, 32'h22);
    host_write(4'd3, 32'h14);
    run(4'd0, 4'd1, 4'd2, 4'd3, 32'd0);
    check_eq("t1_r1", mdl[1], 32'h36);

    // 2: SHRA and ROL with amount taken modulo 32
    host_write(4'd5, 32'h8000_0010);
    host_write(4'd6, 32'h24);
    run(4'd5, 4'd4, 4'd5, 4'd6, 32'd0);
    check_eq("t2_shra", mdl[4], 32'hF800_0001);
    run(4'd8, 4'd4, 4'd5, 4'd6, 32'd0);
    check_eq("t2_rol", mdl[4], 32'h0000_0108);

    // 3: R0 hardwired to zero
    host_write(4'd0, 32'hFFFF);
    check_reg("t3_r0_after_wr", 4'd0);
    host_write(4'd7, 32'd5);
    run(4'd0, 4'd0, 4'd0, 4'd7, 32'd0);
    check_reg("t3_r0_after_wb", 4'd0);
    run(4'd1, 4'd8, 4'd7, 4'd7, 32'd0);

    // 4: start and host write while busy are ignored
    host_write(4'd9, 32'h33);
    d0 = n_done;
    e = predict(4'd0, 4'd2, 4'd3, 32'd0);
    sb.push_back(e);
    start = 1'b1; op = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3; imm = '0;
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hAA;
    tick();
    wr_en = 1'b0; start = 1'b0;
    tick();
    mdl[1] = e.res;
    tick(); tick(); tick(); tick(); tick();
    check_eq("t4_one_done", n_done - d0, 1);
    check_reg("t4_r9", 4'd9);
    check_reg("t4_r1", 4'd1);

    // 5: reserved opcode, then ADDI wrapping to zero
    run(4'd13, 4'd2, 4'd2, 4'd3, 32'd0);
    check_reg("t5_r2_kept", 4'd2);
    host_write(4'd1, 32'd1);
    run(4'd11, 4'd1, 4'd1, 4'd0, 32'hFFFF_FFFF);

    // 6: Clear during EXEC abandons the instruction
    host_write(4'd10, 32'h55);
    d0 = n_done;
    start = 1'b1; op = 4'd0; ra = 4'd10; rb = 4'd2; rc = 4'd3;
    tick();
    start = 1'b0;
    tick();
    do_clear();
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_done", 32'(done), 32'd0);
    check_reg("t6_r10", 4'd10);
    run(4'd11, 4'd1, 4'd0, 4'd0, 32'd7);
    check_eq("t6_one_done", n_done - d0, 1);

    // Random instruction mix
    for (int k = 0; k < 24; k++) begin
      if (($urandom % 3) == 0) host_write(AW'($urandom_range(0, 15)), $urandom);
      run(4'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
          AW'($urandom_range(0, 15)), $urandom);
    end

    tick(); tick();
    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
